// File: rtl/hf_lf_switch_ctrl_pkg.sv
// Shared types and helpers for the HF/LF personality switch sequencer.
// The state encoding is fixed because the state register is visible on debug taps.
package hf_lf_switch_pkg;

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_QUIESCE = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_SETTLE  = 3'd4
    } sw_state_e;

    localparam logic SEL_HF = 1'b1;
    localparam logic SEL_LF = 1'b0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The counter only ever holds values 0 .. max_count-1.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 32'd1) ? $clog2(max_count) : 32'd1;
    endfunction

    // {hf_rst, lf_rst} when only the non-selected core is held in reset.
    function automatic logic [1:0] core_rst(input logic sel_v);
        return {(sel_v != SEL_HF), (sel_v != SEL_LF)};
    endfunction

endpackage

// File: rtl/hf_lf_switch_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// The reset value lets each instance come up in its own idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/hf_lf_switch_ctrl.sv
// HF/LF personality switch sequencer: debounce, wait for SPI idle, quiesce
// the drivers, flip the mux select, reset the incoming core, then release.
module hf_lf_switch_ctrl
    import hf_lf_switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE      = 16,
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned GUARD         = 64,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETTLE        = 32,
    parameter logic        SEL_RESET     = 1'b1
) (
    input  logic ck_1356meg,
    input  logic reset,
    input  logic fpga_switch,
    input  logic ncs,
    output logic sel,
    output logic pwr_gate,
    output logic ssp_gate,
    output logic hf_rst,
    output logic lf_rst,
    output logic busy,
    output logic drain_timeout
);

    localparam int unsigned CNT_MAX = max_u(max_u(DEBOUNCE, DRAIN_TIMEOUT),
                                            max_u(max_u(GUARD, RST_CYCLES), SETTLE));
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD - 32'd1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 32'd1);

    logic             req_s;
    logic             ncs_s;
    sw_state_e        state_r;
    sw_state_e        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             sel_r;
    logic             sel_s;
    logic             dto_r;
    logic             dto_s;
    logic             gate_s;
    logic             hf_rst_s;
    logic             lf_rst_s;
    logic             busy_s;
    logic             pwr_gate_r;
    logic             ssp_gate_r;
    logic             hf_rst_r;
    logic             lf_rst_r;
    logic             busy_r;

    // Request idles at the reset select so reset never triggers a switch.
    sync_2ff #(.RST_VAL(SEL_RESET)) u_req_sync (
        .clk (ck_1356meg),
        .rst (reset),
        .d   (fpga_switch),
        .q   (req_s)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_ncs_sync (
        .clk (ck_1356meg),
        .rst (reset),
        .d   (ncs),
        .q   (ncs_s)
    );

    // Next state, shared counter and output decode of the next state.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sel_s   = sel_r;
        dto_s   = dto_r;
        case (state_r)
            ST_ACTIVE: begin
                if (req_s == sel_r) begin
                    cnt_s = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = ST_DRAIN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (req_s == sel_r) begin
                    state_s = ST_ACTIVE;
                    cnt_s   = CNT_ZERO;
                end else if (ncs_s) begin
                    state_s = ST_QUIESCE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DRAIN_LAST) begin
                    state_s = ST_QUIESCE;
                    cnt_s   = CNT_ZERO;
                    dto_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_QUIESCE: begin
                if (cnt_r == GUARD_LAST) begin
                    state_s = ST_SWITCH;
                    cnt_s   = CNT_ZERO;
                    sel_s   = ~sel_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SWITCH: begin
                if (cnt_r == RST_LAST) begin
                    state_s = ST_SETTLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_ACTIVE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_SWITCH;
                cnt_s   = CNT_ZERO;
            end
        endcase

        gate_s                = 1'b1;
        {hf_rst_s, lf_rst_s}  = core_rst(sel_s);
        case (state_s)
            ST_ACTIVE, ST_DRAIN: begin
                gate_s = 1'b0;
            end
            ST_QUIESCE, ST_SETTLE: begin
                gate_s = 1'b1;
            end
            ST_SWITCH: begin
                hf_rst_s = 1'b1;
                lf_rst_s = 1'b1;
            end
            default: begin
                hf_rst_s = 1'b1;
                lf_rst_s = 1'b1;
            end
        endcase
        busy_s = (state_s != ST_ACTIVE);
    end

    // State, counter and every output are registered together.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            state_r    <= ST_SWITCH;
            cnt_r      <= CNT_ZERO;
            sel_r      <= SEL_RESET;
            dto_r      <= 1'b0;
            pwr_gate_r <= 1'b1;
            ssp_gate_r <= 1'b1;
            hf_rst_r   <= 1'b1;
            lf_rst_r   <= 1'b1;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sel_r      <= sel_s;
            dto_r      <= dto_s;
            pwr_gate_r <= gate_s;
            ssp_gate_r <= gate_s;
            hf_rst_r   <= hf_rst_s;
            lf_rst_r   <= lf_rst_s;
            busy_r     <= busy_s;
        end
    end

    assign sel           = sel_r;
    assign pwr_gate      = pwr_gate_r;
    assign ssp_gate      = ssp_gate_r;
    assign hf_rst        = hf_rst_r;
    assign lf_rst        = lf_rst_r;
    assign busy          = busy_r;
    assign drain_timeout = dto_r;

endmodule
